// File: rtl/life_engine_if.sv
// Control, load and display-read signals of the Game of Life engine.
// master drives the controls; slave is the engine.
interface life_engine_if #(
    parameter int AW = 6
);
    logic          frame_tick;
    logic          run;
    logic          step;
    logic          clear;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic          load_val;
    logic [AW-1:0] rd_addr;
    logic          rd_cell;
    logic          busy;
    logic          gen_done;
    logic [15:0]   gen_count;
    logic [AW:0]   alive_count;

    modport master (
        output frame_tick, run, step, clear, load_en, load_addr, load_val, rd_addr,
        input  rd_cell, busy, gen_done, gen_count, alive_count
    );

    modport slave (
        input  frame_tick, run, step, clear, load_en, load_addr, load_val, rd_addr,
        output rd_cell, busy, gen_done, gen_count, alive_count
    );
endinterface

// File: rtl/life_engine.sv
// Double-buffered Conway Game of Life engine: one cell per clock into nxt,
// then a single-cycle atomic commit to the displayed board cur.
module life_engine #(
    parameter int BIT_W          = 3,
    parameter int BIT_H          = 3,
    parameter int WRAP           = 0,
    parameter int FRAMES_PER_GEN = 60
) (
    input logic           clk,
    input logic           reset,
    life_engine_if.slave  bus
);
    localparam int AW   = BIT_W + BIT_H;
    localparam int SIZE = 1 << AW;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t          state;
    logic [SIZE-1:0] cur;
    logic [SIZE-1:0] nxt;
    logic [AW-1:0]   idx;
    logic [7:0]      fcnt;
    logic [AW:0]     pop;
    logic [AW:0]     alive;
    logic [15:0]     gen_cnt;
    logic            busy;
    logic            gen_done;

    logic [BIT_W-1:0] col;
    logic [BIT_H-1:0] row;
    logic [BIT_W-1:0] nc;
    logic [BIT_H-1:0] nr;
    logic             col_ok;
    logic             row_ok;
    logic [3:0]       n;
    logic             new_cell;
    logic             tick_due;
    logic             start;

    assign col = idx[BIT_W-1:0];
    assign row = idx[AW-1:BIT_W];

    // k walks the 3x3 window; k%3 selects col-1/col/col+1, k/3 selects the row.
    always_comb begin
        n      = '0;
        nc     = '0;
        nr     = '0;
        col_ok = 1'b0;
        row_ok = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            nc     = col + BIT_W'(k % 3) - BIT_W'(1);
            nr     = row + BIT_H'(k / 3) - BIT_H'(1);
            col_ok = (WRAP != 0) || !((k % 3 == 0 && col == '0) || (k % 3 == 2 && col == '1));
            row_ok = (WRAP != 0) || !((k / 3 == 0 && row == '0) || (k / 3 == 2 && row == '1));
            if (k != 4 && col_ok && row_ok)
                n = n + 4'(cur[{nr, nc}]);
        end
    end

    assign new_cell = (n == 4'd3) | (cur[idx] & (n == 4'd2));
    assign tick_due = bus.run & bus.frame_tick & (fcnt == 8'(FRAMES_PER_GEN - 1));
    assign start    = bus.step | tick_due;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= '0;
            nxt      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            pop      <= '0;
            alive    <= '0;
            gen_cnt  <= '0;
            busy     <= 1'b0;
            gen_done <= 1'b0;
        end else begin
            gen_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        cur   <= '0;
                        alive <= '0;
                    end else if (bus.load_en) begin
                        cur[bus.load_addr] <= bus.load_val;
                        if (bus.load_val && !cur[bus.load_addr])
                            alive <= alive + 1'b1;
                        else if (!bus.load_val && cur[bus.load_addr])
                            alive <= alive - 1'b1;
                    end else if (start) begin
                        state <= CALC;
                        idx   <= '0;
                        pop   <= '0;
                        fcnt  <= '0;
                        busy  <= 1'b1;
                    end else if (bus.run && bus.frame_tick) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                CALC: begin
                    nxt[idx] <= new_cell;
                    pop      <= pop + (AW+1)'(new_cell);
                    idx      <= idx + 1'b1;
                    if (idx == '1)
                        state <= COMMIT;
                end
                COMMIT: begin
                    cur      <= nxt;
                    alive    <= pop;
                    gen_cnt  <= gen_cnt + 16'd1;
                    busy     <= 1'b0;
                    gen_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_cell     = cur[bus.rd_addr];
    assign bus.busy        = busy;
    assign bus.gen_done    = gen_done;
    assign bus.gen_count   = gen_cnt;
    assign bus.alive_count = alive;
endmodule
